// File: rtl/mem_pkg.sv
// Shared data-memory definitions: access-width encodings and the access fault check.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE    = 2'b00;
  localparam logic [1:0] MEM_HALF    = 2'b01;
  localparam logic [1:0] MEM_WORD    = 2'b10;
  localparam logic [1:0] MEM_ILLEGAL = 2'b11;

  // Faults on an illegal width, a misaligned half/word, or any addressed byte at or beyond size_bytes.
  // The address is zero-extended to 64 bits so the range sum cannot wrap.
  function automatic logic mem_access_fault(input logic [63:0] addr,
                                            input logic [1:0]  width,
                                            input logic [63:0] size_bytes);
    logic [63:0] nbytes;
    logic        fault;
    fault  = 1'b0;
    nbytes = 64'd4;
    case (width)
      MEM_BYTE: nbytes = 64'd1;
      MEM_HALF: begin
        nbytes = 64'd2;
        fault  = addr[0];
      end
      MEM_WORD: begin
        nbytes = 64'd4;
        fault  = |addr[1:0];
      end
      default: fault = 1'b1;
    endcase
    if (addr + nbytes > size_bytes) fault = 1'b1;
    return fault;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit data word: store byte enables and data placement,
// and load extraction with sign or zero extension.
module mem_lane_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      addr_lo_i,
  input  logic [1:0]      width_i,
  input  logic            sign_extend_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);
  import mem_pkg::*;

  logic [4:0]      lane_shift;
  logic [XLEN-1:0] rword_shifted;

  assign lane_shift    = {addr_lo_i, 3'b000};
  assign wdata_o       = wdata_i << lane_shift;
  assign rword_shifted = rword_i >> lane_shift;

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    be_o    = 4'b0000;
    rdata_o = '0;
    case (width_i)
      MEM_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        rdata_o = {{(XLEN-8){sign_extend_i & rword_shifted[7]}}, rword_shifted[7:0]};
      end
      MEM_HALF: begin
        be_o    = 4'b0011 << addr_lo_i;
        rdata_o = {{(XLEN-16){sign_extend_i & rword_shifted[15]}}, rword_shifted[15:0]};
      end
      MEM_WORD: begin
        be_o    = 4'b1111;
        rdata_o = rword_i;
      end
      default: begin
        be_o    = 4'b0000;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: single outstanding load/store against an internal byte-addressable
// array, with configurable wait states before a registered response.
module data_mem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_width,
  input  logic            req_sign_extend,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault
);
  import mem_pkg::*;

  localparam int unsigned      IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned      CNT_W      = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [63:0]      SIZE_BYTES = 64'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic [XLEN-1:0]   mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0]  mem_idx;
  logic [XLEN-1:0]   rd_word;
  logic [3:0]        be;
  logic [XLEN-1:0]   wdata_lanes;
  logic [XLEN-1:0]   rdata_ext;
  logic              accept;
  logic              req_fault;
  logic              mem_we;
  logic              rsp_hs;

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_hs    = rsp_valid_q && rsp_ready;
  assign req_fault = mem_access_fault(64'(req_addr), req_width, SIZE_BYTES);
  assign mem_idx   = req_addr[IDX_W+1:2];
  assign rd_word   = mem_q[mem_idx];

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .addr_lo_i    (req_addr[1:0]),
    .width_i      (req_width),
    .sign_extend_i(req_sign_extend),
    .wdata_i      (req_wdata),
    .rword_i      (rd_word),
    .be_o         (be),
    .wdata_o      (wdata_lanes),
    .rdata_o      (rdata_ext)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: if (rsp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // rsp_valid is registered one cycle after entering RESP; the payload is captured at acceptance.
  always_comb begin
    rsp_valid_d = (state_q == ST_RESP) && !rsp_hs;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    mem_we      = 1'b0;
    if (accept) begin
      fault_d = req_fault;
      rdata_d = (req_fault || req_write) ? '0 : rdata_ext;
      mem_we  = req_write && !req_fault;
    end
  end

  // NOTE: the array is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[mem_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DEPTH_WORDS = 1024;
  localparam int unsigned LATENCY     = 2;
  localparam int          RSP_LAT     = LATENCY + 1;

  localparam logic [1:0]  EXT_W [8] = '{MEM_BYTE, MEM_BYTE, MEM_HALF, MEM_HALF,
                                        MEM_BYTE, MEM_HALF, MEM_WORD, MEM_BYTE};
  localparam logic [31:0] EXT_A [8] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10, 32'h10, 32'h10, 32'h11};
  localparam logic        EXT_S [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [31:0] EXT_E [8] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_DEAD,
                                        32'hFFFF_FFEF, 32'hFFFF_BEEF, 32'hDEAD_BEEF, 32'h0000_00BE};

  localparam logic        FLT_WR [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [31:0] FLT_A  [6] = '{32'h11, 32'h1000, 32'h10, 32'h12, 32'hFFF, 32'h1000};
  localparam logic [1:0]  FLT_W  [6] = '{MEM_HALF, MEM_WORD, MEM_ILLEGAL, MEM_WORD, MEM_HALF, MEM_BYTE};

  logic            clock, reset;
  logic            req_valid, req_ready, req_write, req_sign_extend;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic [1:0]      req_width;
  logic            rsp_valid, rsp_ready, rsp_fault;
  logic [XLEN-1:0] rsp_rdata;

  int n_pass  = 0;
  int n_total = 0;

  data_mem_responder #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_width      (req_width),
    .req_sign_extend(req_sign_extend),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_fault      (rsp_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One complete transaction; lat = clock edges from acceptance until rsp_valid is seen (-1 on timeout).
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] wd, input logic s,
                      output logic [31:0] rd, output logic f, output int lat);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_width = wd; req_sign_extend = s;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    rd = rsp_rdata;
    f  = rsp_fault;
    if (!rsp_valid) begin
      lat = -1;
      return;
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = '1;
    req_width = MEM_WORD; req_sign_extend = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_total++; if (req_ready !== 1'b0) $display("FAIL reset req_ready: got %b, expected 0", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid: got %b, expected 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_rdata !== '0) $display("FAIL reset rsp_rdata: got %h, expected 0", rsp_rdata); else n_pass++;
    n_total++; if (rsp_fault !== 1'b0) $display("FAIL reset rsp_fault: got %b, expected 0", rsp_fault); else n_pass++;
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    n_total++; if (req_ready !== 1'b1) $display("FAIL post-reset req_ready: got %b, expected 1", req_ready); else n_pass++;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic f; int lat;
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, MEM_WORD, 1'b0, rd, f, lat);
    n_total++; if (lat != RSP_LAT) $display("FAIL store latency: got %0d, expected %0d", lat, RSP_LAT); else n_pass++;
    n_total++; if (f !== 1'b0) $display("FAIL store fault: got %b, expected 0", f); else n_pass++;
    n_total++; if (rd !== 32'h0) $display("FAIL store rdata: got %h, expected 00000000", rd); else n_pass++;
    xact(1'b0, 32'h10, 32'h0, MEM_WORD, 1'b0, rd, f, lat);
    n_total++; if (lat != RSP_LAT) $display("FAIL load latency: got %0d, expected %0d", lat, RSP_LAT); else n_pass++;
    n_total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL load rdata: got %h, expected deadbeef", rd); else n_pass++;
    n_total++; if (f !== 1'b0) $display("FAIL load fault: got %b, expected 0", f); else n_pass++;
  endtask

  task automatic test_extension();
    logic [31:0] rd; logic f; int lat;
    for (int i = 0; i < 8; i++) begin
      xact(1'b0, EXT_A[i], 32'h0, EXT_W[i], EXT_S[i], rd, f, lat);
      n_total++;
      if (rd !== EXT_E[i]) $display("FAIL ext[%0d] rdata: got %h, expected %h", i, rd, EXT_E[i]);
      else n_pass++;
      n_total++;
      if (f !== 1'b0) $display("FAIL ext[%0d] fault: got %b, expected 0", i, f);
      else n_pass++;
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic f; int lat;
    xact(1'b1, 32'h30, 32'h1122_3344, MEM_WORD, 1'b0, rd, f, lat);
    xact(1'b1, 32'h31, 32'hFFFF_FFAB, MEM_BYTE, 1'b0, rd, f, lat);
    n_total++; if (f !== 1'b0) $display("FAIL byte store fault: got %b, expected 0", f); else n_pass++;
    xact(1'b1, 32'h32, 32'h9999_CDEF, MEM_HALF, 1'b0, rd, f, lat);
    n_total++; if (f !== 1'b0) $display("FAIL half store fault: got %b, expected 0", f); else n_pass++;
    xact(1'b0, 32'h30, 32'h0, MEM_WORD, 1'b0, rd, f, lat);
    n_total++; if (rd !== 32'hCDEF_AB44) $display("FAIL lane merge rdata: got %h, expected cdefab44", rd); else n_pass++;
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic f; int lat;
    for (int i = 0; i < 6; i++) begin
      xact(FLT_WR[i], FLT_A[i], 32'h0000_1234, FLT_W[i], 1'b1, rd, f, lat);
      n_total++;
      if (f !== 1'b1) $display("FAIL fault[%0d] flag: got %b, expected 1", i, f);
      else n_pass++;
      n_total++;
      if (rd !== 32'h0) $display("FAIL fault[%0d] rdata: got %h, expected 00000000", i, rd);
      else n_pass++;
    end
    xact(1'b0, 32'h10, 32'h0, MEM_WORD, 1'b0, rd, f, lat);
    n_total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL after faulted store rdata: got %h, expected deadbeef", rd); else n_pass++;
    xact(1'b1, 32'hFFC, 32'h1357_9BDF, MEM_WORD, 1'b0, rd, f, lat);
    n_total++; if (f !== 1'b0) $display("FAIL last word store fault: got %b, expected 0", f); else n_pass++;
    xact(1'b0, 32'hFFF, 32'h0, MEM_BYTE, 1'b0, rd, f, lat);
    n_total++; if (rd !== 32'h13 || f !== 1'b0) $display("FAIL last byte load: got %h/%b, expected 00000013/0", rd, f); else n_pass++;
    xact(1'b0, 32'hFFE, 32'h0, MEM_HALF, 1'b0, rd, f, lat);
    n_total++; if (rd !== 32'h1357 || f !== 1'b0) $display("FAIL last half load: got %h/%b, expected 00001357/0", rd, f); else n_pass++;
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clock);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_width = MEM_WORD; req_sign_extend = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n_total++; if (req_ready !== 1'b0) $display("FAIL bp req_ready after accept: got %b, expected 0", req_ready); else n_pass++;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL bp rsp_valid timeout: got %b, expected 1", rsp_valid); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++; if (rsp_valid !== 1'b1) $display("FAIL bp hold[%0d] rsp_valid: got %b, expected 1", i, rsp_valid); else n_pass++;
      n_total++; if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL bp hold[%0d] rdata: got %h, expected deadbeef", i, rsp_rdata); else n_pass++;
      n_total++; if (req_ready !== 1'b0) $display("FAIL bp hold[%0d] req_ready: got %b, expected 0", i, req_ready); else n_pass++;
      if (i < 5) @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL bp after handshake rsp_valid: got %b, expected 0", rsp_valid); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL bp after handshake req_ready: got %b, expected 1", req_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int   acc[$];
    int   edge_n, n_rsp, guard;
    logic accepting;
    edge_n = 0; n_rsp = 0;
    @(negedge clock);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_width = MEM_WORD; req_sign_extend = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (acc.size() == 3) break;
      if (rsp_valid) begin
        n_rsp++;
        n_total++;
        if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL b2b rdata: got %h, expected deadbeef", rsp_rdata);
        else n_pass++;
      end
      accepting = req_ready;
      @(posedge clock);
      edge_n++;
      if (accepting) acc.push_back(edge_n);
      @(negedge clock);
    end
    req_valid = 1'b0;
    n_total++; if (acc.size() != 3) $display("FAIL b2b acceptances: got %0d, expected 3", acc.size()); else n_pass++;
    if (acc.size() == 3) begin
      for (int k = 1; k < 3; k++) begin
        n_total++;
        if (acc[k] - acc[k-1] != LATENCY + 3)
          $display("FAIL b2b gap[%0d]: got %0d, expected %0d", k, acc[k] - acc[k-1], LATENCY + 3);
        else n_pass++;
      end
    end
    n_total++; if (n_rsp != 2) $display("FAIL b2b responses: got %0d, expected 2", n_rsp); else n_pass++;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    @(negedge clock);
    rsp_ready = 1'b0;
    n_total++; if (req_ready !== 1'b1) $display("FAIL b2b drain req_ready: got %b, expected 1", req_ready); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic f; int lat;
    logic        seen;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h0000_00A5;
    req_width = MEM_BYTE; req_sign_extend = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; req_write = 1'b0;
    n_total++; if (req_ready !== 1'b0) $display("FAIL mid-op req_ready in wait: got %b, expected 0", req_ready); else n_pass++;
    reset = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL mid-op reset rsp_valid: got %b, expected 0", rsp_valid); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL mid-op reset req_ready: got %b, expected 0", req_ready); else n_pass++;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    n_total++; if (seen !== 1'b0) $display("FAIL mid-op dropped response: got %b, expected 0", seen); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL mid-op idle req_ready: got %b, expected 1", req_ready); else n_pass++;
    xact(1'b0, 32'h20, 32'h0, MEM_BYTE, 1'b0, rd, f, lat);
    n_total++; if (rd !== 32'hA5 || f !== 1'b0) $display("FAIL mid-op store kept: got %h/%b, expected 000000a5/0", rd, f); else n_pass++;
    xact(1'b0, 32'h20, 32'h0, MEM_BYTE, 1'b1, rd, f, lat);
    n_total++; if (rd !== 32'hFFFF_FFA5) $display("FAIL mid-op signed byte: got %h, expected ffffffa5", rd); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extension();
    test_byte_enables();
    test_faults();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
